// File: rtl/uart_tx_sched_if.sv
// Requester handshakes and transmitter-side outputs of the UART transmit scheduler.
// master = requester/observer side, slave = scheduler side.
interface uart_tx_sched_if #(
  parameter int DEPTH = 8
) ();
  logic                     a_valid;
  logic [7:0]               a_data;
  logic                     a_ready;
  logic                     b_valid;
  logic [7:0]               b_data;
  logic                     b_ready;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_level;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, tx_start, tx_data, busy, fifo_level
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, tx_start, tx_data, busy, fifo_level
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding a UART transmitter through a FIFO;
// tx_start pulses are spaced by a full frame so a frame in flight is never restarted.
module uart_tx_sched #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int DEPTH    = 8
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.slave  bus
);
  localparam int PERIOD       = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = 10 * PERIOD + 4;
  localparam int AW           = $clog2(DEPTH);
  localparam int LW           = AW + 1;
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            last_b;
  logic            tx_start, room, a_rdy, b_rdy, push, pop;
  logic [7:0]      tx_data, push_data;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  always_comb begin
    room      = (level != LW'(DEPTH));
    a_rdy     = room && bus.a_valid && (!bus.b_valid || last_b);
    b_rdy     = room && bus.b_valid && (!bus.a_valid || !last_b);
    push      = a_rdy || b_rdy;
    push_data = a_rdy ? bus.a_data : bus.b_data;
    pop       = (state == IDLE) && (level != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_b   <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        last_b <= b_rdy;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data  <= mem[rd_ptr];
          tx_start <= 1'b1;
          cnt      <= CW'(FRAME_CYCLES - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready    = a_rdy;
  assign bus.b_ready    = b_rdy;
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = tx_data;
  assign bus.busy       = (state == WAIT) || (level != '0);
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at PERIOD=10 (FRAME_CYCLES=104), DEPTH=4.
module tb_uart_tx_sched;
  logic clk, rst;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;

  uart_tx_sched_if #(.DEPTH(4)) bus ();

  uart_tx_sched #(.CLK_FREQ(1000), .UART_BPS(100), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_q[$];
  int         txc_q[$];
  always @(negedge clk) begin
    if (bus.tx_start) begin
      tx_q.push_back(bus.tx_data);
      txc_q.push_back(cyc);
    end
  end

  logic [7:0] a_src[$], b_src[$];
  int         acc_q[$], lvl_q[$];
  int         both_rdy, max_lvl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call just after a rising edge e0; acc_q holds accept edges as offsets from e0,
  // lvl_q[i] is the level after edge e0+i.
  task automatic run();
    int ai = 0, bi = 0, i = 0;
    acc_q.delete(); lvl_q.delete();
    both_rdy = 0; max_lvl = 0;
    while ((ai < a_src.size() || bi < b_src.size()) && i < 5000) begin
      bus.a_valid = (ai < a_src.size());
      bus.a_data  = (ai < a_src.size()) ? a_src[ai] : 8'h00;
      bus.b_valid = (bi < b_src.size());
      bus.b_data  = (bi < b_src.size()) ? b_src[bi] : 8'h00;
      @(negedge clk);
      lvl_q.push_back(int'(bus.fifo_level));
      if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
      if (bus.a_ready && bus.b_ready) both_rdy++;
      if (bus.a_ready) begin acc_q.push_back(i + 1); ai++; end
      else if (bus.b_ready) begin acc_q.push_back(i + 1); bi++; end
      @(posedge clk); #1;
      i++;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    if (i >= 5000) chk("run_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int drop);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("idle_timeout", 0, 1);
    drop = cyc;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, tx_q.size(), exp.size());
    foreach (exp[k]) chk(tag, (k < tx_q.size()) ? tx_q[k] : 8'hxx, exp[k]);
  endtask

  initial begin
    int e0, drop;
    logic [7:0] exp[$];
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_data = 8'h00;
    bus.b_valid = 1'b0; bus.b_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single byte
    tx_q.delete(); txc_q.delete();
    a_src = '{8'h55}; b_src.delete();
    e0 = cyc;
    run();
    chk("single_accept", acc_q.size() > 0 ? acc_q[0] : 0, 1);
    wait_idle(drop);
    chk("single_pulses", tx_q.size(), 1);
    chk("single_pulse_edge", txc_q.size() > 0 ? txc_q[0] - e0 : 0, 2);
    chk("single_data", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h55);
    chk("single_busy_drop", txc_q.size() > 0 ? drop - txc_q[0] : 0, 104);

    // reset mid-frame with 3 bytes queued
    a_src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    e0 = cyc;
    run();
    while (cyc < e0 + 107) @(negedge clk);
    chk("pre_rst_level", bus.fifo_level, 3);
    chk("pre_rst_pulse", bus.tx_start, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_start", bus.tx_start, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    chk("mid_rst_level", bus.fifo_level, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.a_valid = 1'b1; #1;
    chk("rst_a_ready", {bus.a_ready, bus.b_ready}, 2'b10);
    bus.a_valid = 1'b0; bus.b_valid = 1'b1; #1;
    chk("rst_b_ready", {bus.a_ready, bus.b_ready}, 2'b01);
    bus.b_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tx_q.delete(); txc_q.delete();
    a_src = '{8'h41};
    e0 = cyc;
    run();
    chk("post_rst_accept", acc_q.size() > 0 ? acc_q[0] : 0, 1);
    wait_idle(drop);
    chk("post_rst_pulse_edge", txc_q.size() > 0 ? txc_q[0] - e0 : 0, 2);
    chk_seq("post_rst_data", '{8'h41});

    // contention from a fresh reset: A wins first
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    tx_q.delete(); txc_q.delete();
    a_src = '{8'h10, 8'h11, 8'h12, 8'h13};
    b_src = '{8'h20, 8'h21, 8'h22, 8'h23};
    run();
    wait_idle(drop);
    chk("cont_both_ready", both_rdy, 0);
    chk_seq("cont_data", '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23});
    chk("cont_spacing01", txc_q.size() > 1 ? txc_q[1] - txc_q[0] : 0, 105);
    chk("cont_spacing23", txc_q.size() > 3 ? txc_q[3] - txc_q[2] : 0, 105);

    // full: 6 bytes back-to-back from A
    tx_q.delete(); txc_q.delete();
    a_src = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45}; b_src.delete();
    run();
    chk("full_accepts", acc_q.size(), 6);
    chk("full_last_accept", acc_q.size() > 5 ? acc_q[5] : 0, 108);
    chk("full_level", lvl_q.size() > 5 ? lvl_q[5] : 0, 4);
    chk("full_hold_level", lvl_q.size() > 106 ? lvl_q[106] : 0, 4);
    chk("full_pop_no_push", lvl_q.size() > 107 ? lvl_q[107] : 0, 3);
    wait_idle(drop);
    chk_seq("full_data", '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45});

    // wrap-around: 20 bytes from B
    tx_q.delete(); txc_q.delete();
    a_src.delete(); b_src.delete(); exp.delete();
    for (int k = 0; k < 20; k++) begin b_src.push_back(8'(k)); exp.push_back(8'(k)); end
    run();
    wait_idle(drop);
    chk("wrap_max_level", max_lvl, 4);
    chk_seq("wrap_data", exp);

    // push and pop on the same edge at level 3
    tx_q.delete(); txc_q.delete();
    b_src = '{8'h30, 8'h31, 8'h32, 8'h33};
    e0 = cyc;
    run();
    while (cyc < e0 + 106) begin @(posedge clk); #1; end
    chk("pp_level_before", bus.fifo_level, 3);
    b_src = '{8'h34};
    run();
    chk("pp_accept", acc_q.size() > 0 ? acc_q[0] : 0, 1);
    chk("pp_pulse", bus.tx_start, 1);
    chk("pp_level", bus.fifo_level, 3);
    wait_idle(drop);
    chk_seq("pp_data", '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
